// File: rtl/alu_multiciclo_nbits_if.sv
// alu_multiciclo_nbits_if: operand/result/handshake bundle between the control FSM and the multicycle ALU
interface alu_multiciclo_nbits_if #(parameter int N = 8);
  logic         start_i;
  logic [N-1:0] a_i;
  logic [N-1:0] b_i;
  logic [3:0]   operacion_i;
  logic [N-1:0] resultado_o;
  logic [N-1:0] hi_o;
  logic [N-1:0] lo_o;
  logic         zero_o;
  logic         overflow_o;
  logic         c_o;
  logic         div_cero_o;
  logic         busy_o;
  logic         done_o;
  modport master (
    output start_i, a_i, b_i, operacion_i,
    input  resultado_o, hi_o, lo_o, zero_o, overflow_o, c_o, div_cero_o, busy_o, done_o
  );
  modport slave (
    input  start_i, a_i, b_i, operacion_i,
    output resultado_o, hi_o, lo_o, zero_o, overflow_o, c_o, div_cero_o, busy_o, done_o
  );
endinterface

// File: rtl/alu_multiciclo_nbits.sv
// alu_multiciclo_nbits: N-bit ALU with registered flags, iterative MULTU (shift-add) and DIVU (restoring) into HI/LO
module alu_multiciclo_nbits #(
  parameter int N = 8
) (
  input logic clk_i,
  input logic rst_i,
  alu_multiciclo_nbits_if.slave bus
);
  localparam int CW = $clog2(N + 1);
  localparam logic [3:0] OP_AND = 4'b0000, OP_OR = 4'b0001, OP_ADD = 4'b0010, OP_SUB = 4'b0110,
                         OP_SLT = 4'b0111, OP_NOR = 4'b1100, OP_MUL = 4'b1000, OP_DIV = 4'b1001;
  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
  state_t state, state_n;
  logic [2*N-1:0] acc;
  logic [N-1:0] a_q, b_q;
  logic [CW-1:0] cnt;
  logic [N-1:0] bx, alu_r;
  logic [N:0] sum;
  logic arith, alu_c, alu_v;
  logic [N:0] msum, rsh;
  logic [2*N-1:0] mul_next, div_next;
  logic [N-1:0] rdiff;
  logic ge, last;
  always_comb begin
    arith = bus.operacion_i == OP_ADD || bus.operacion_i == OP_SUB;
    bx = bus.operacion_i == OP_SUB ? ~bus.b_i : bus.b_i;
    sum = {1'b0, bus.a_i} + {1'b0, bx} + {{N{1'b0}}, bus.operacion_i == OP_SUB};
    alu_r = bus.operacion_i == OP_AND ? bus.a_i & bus.b_i :
            bus.operacion_i == OP_OR  ? bus.a_i | bus.b_i :
            arith                     ? sum[N-1:0] :
            bus.operacion_i == OP_SLT ? {{(N-1){1'b0}}, $signed(bus.a_i) < $signed(bus.b_i)} :
            bus.operacion_i == OP_NOR ? ~(bus.a_i | bus.b_i) : '0;
    alu_c = arith & sum[N];
    alu_v = arith & (bus.a_i[N-1] == bx[N-1]) & (sum[N-1] != bus.a_i[N-1]);
  end
  // acc is {product high, product low} for MULTU and {remainder, quotient} for DIVU
  always_comb begin
    msum = {1'b0, acc[2*N-1:N]} + {1'b0, a_q[0] ? b_q : {N{1'b0}}};
    mul_next = {msum, acc[N-1:1]};
    rsh = acc[2*N-1:N-1];
    ge = rsh >= {1'b0, b_q};
    rdiff = rsh[N-1:0] - b_q;
    div_next = {ge ? rdiff : rsh[N-1:0], acc[N-2:0], ge};
    last = cnt == CW'(1);
  end
  always_comb begin
    state_n = state;
    if (state == IDLE && bus.start_i)
      state_n = bus.operacion_i == OP_MUL ? MUL :
                (bus.operacion_i == OP_DIV && bus.b_i != '0) ? DIV : DONE;
    else if (state == MUL || state == DIV)
      state_n = last ? DONE : state;
    else if (state == DONE)
      state_n = IDLE;
  end
  assign bus.busy_o = state == MUL || state == DIV;
  assign bus.done_o = state == DONE;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
      acc <= '0;
      a_q <= '0;
      b_q <= '0;
      cnt <= '0;
      bus.resultado_o <= '0;
      bus.hi_o <= '0;
      bus.lo_o <= '0;
      bus.zero_o <= 1'b0;
      bus.overflow_o <= 1'b0;
      bus.c_o <= 1'b0;
      bus.div_cero_o <= 1'b0;
    end else begin
      state <= state_n;
      if (state == IDLE && bus.start_i) begin
        a_q <= bus.a_i;
        b_q <= bus.b_i;
        cnt <= CW'(N);
        if (bus.operacion_i == OP_MUL) begin
          acc <= '0;
        end else if (bus.operacion_i == OP_DIV) begin
          acc <= {{N{1'b0}}, bus.a_i};
          if (bus.b_i == '0) begin
            bus.lo_o <= '1;
            bus.hi_o <= bus.a_i;
            bus.resultado_o <= '1;
            bus.div_cero_o <= 1'b1;
            bus.zero_o <= 1'b0;
            bus.c_o <= 1'b0;
            bus.overflow_o <= 1'b0;
          end
        end else begin
          bus.resultado_o <= alu_r;
          bus.zero_o <= alu_r == '0 && (arith || bus.operacion_i == OP_AND || bus.operacion_i == OP_OR ||
                                        bus.operacion_i == OP_SLT || bus.operacion_i == OP_NOR);
          bus.c_o <= alu_c;
          bus.overflow_o <= alu_v;
        end
      end else if (state == MUL || state == DIV) begin
        acc <= state == MUL ? mul_next : div_next;
        a_q <= a_q >> 1;
        cnt <= cnt - CW'(1);
        if (last) begin
          bus.hi_o <= state == MUL ? mul_next[2*N-1:N] : div_next[2*N-1:N];
          bus.lo_o <= state == MUL ? mul_next[N-1:0] : div_next[N-1:0];
          bus.resultado_o <= state == MUL ? mul_next[N-1:0] : div_next[N-1:0];
          bus.zero_o <= (state == MUL ? mul_next[N-1:0] : div_next[N-1:0]) == '0;
          bus.c_o <= 1'b0;
          bus.overflow_o <= 1'b0;
          if (state == DIV) bus.div_cero_o <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_alu_multiciclo_nbits.sv
// tb_alu_multiciclo_nbits: directed vectors, expected responses queued at issue and checked by a done_o monitor
module tb_alu_multiciclo_nbits;
  localparam int N = 8;
  typedef struct {
    logic [7:0] res, hi, lo;
    logic z, c, v, dz;
    string name;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  exp_t sb[$];
  int errors = 0;
  int checks = 0;
  alu_multiciclo_nbits_if #(.N(N)) bus ();
  alu_multiciclo_nbits #(.N(N)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask
  always @(negedge clk) begin
    if (!rst && bus.done_o) begin
      exp_t e;
      chk("done_vs_busy", {31'd0, bus.busy_o}, 32'd0);
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk({e.name, ".res"}, {24'd0, bus.resultado_o}, {24'd0, e.res});
        chk({e.name, ".hi"}, {24'd0, bus.hi_o}, {24'd0, e.hi});
        chk({e.name, ".lo"}, {24'd0, bus.lo_o}, {24'd0, e.lo});
        chk({e.name, ".flags"}, {28'd0, bus.zero_o, bus.c_o, bus.overflow_o, bus.div_cero_o},
            {28'd0, e.z, e.c, e.v, e.dz});
      end
    end
  end
  task automatic issue(input string name, input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] res, input logic [7:0] hi, input logic [7:0] lo,
                       input logic z, input logic c, input logic v, input logic dz,
                       input int exp_busy, input bit poke);
    exp_t e;
    int nb = 0;
    int t = 0;
    e.res = res; e.hi = hi; e.lo = lo; e.z = z; e.c = c; e.v = v; e.dz = dz; e.name = name;
    sb.push_back(e);
    @(negedge clk);
    bus.operacion_i = op; bus.a_i = a; bus.b_i = b; bus.start_i = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0;
    bus.a_i = ~a; bus.b_i = 8'd1; bus.operacion_i = 4'b0001;
    while (!bus.done_o && t < 40) begin
      if (bus.busy_o) nb++;
      bus.start_i = poke && nb == 3;
      if (poke && nb == 3) begin
        bus.a_i = 8'd1; bus.b_i = 8'd1; bus.operacion_i = 4'b0010;
      end
      @(negedge clk);
      t++;
    end
    bus.start_i = 1'b0;
    chk({name, ".timeout"}, {31'd0, bus.done_o}, 32'd1);
    chk({name, ".busy_cycles"}, nb, exp_busy);
  endtask
  initial begin
    bus.start_i = 1'b0; bus.a_i = '0; bus.b_i = '0; bus.operacion_i = '0;
    repeat (3) @(negedge clk);
    chk("reset.outs", {bus.resultado_o, bus.hi_o, bus.lo_o, 8'd0}, 32'd0);
    chk("reset.flags", {26'd0, bus.zero_o, bus.overflow_o, bus.c_o, bus.div_cero_o, bus.busy_o, bus.done_o}, 32'd0);
    rst = 1'b0;
    //           name     op       a      b      res    hi     lo     z  c  v  dz busy poke
    issue("add1",  4'b0010, 8'd100, 8'd27,  8'd127, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0);
    issue("add2",  4'b0010, 8'd100, 8'd100, 8'hC8,  8'h00, 8'h00, 0, 0, 1, 0, 0, 0);
    issue("add3",  4'b0010, 8'hFF,  8'h01,  8'h00,  8'h00, 8'h00, 1, 1, 0, 0, 0, 0);
    issue("sub1",  4'b0110, 8'd5,   8'd7,   8'hFE,  8'h00, 8'h00, 0, 0, 0, 0, 0, 0);
    issue("sub2",  4'b0110, 8'h80,  8'h01,  8'h7F,  8'h00, 8'h00, 0, 1, 1, 0, 0, 0);
    issue("slt1",  4'b0111, 8'd5,   8'd7,   8'h01,  8'h00, 8'h00, 0, 0, 0, 0, 0, 0);
    issue("slt2",  4'b0111, 8'h80,  8'h01,  8'h01,  8'h00, 8'h00, 0, 0, 0, 0, 0, 0);
    issue("nor",   4'b1100, 8'hF0,  8'h0F,  8'h00,  8'h00, 8'h00, 1, 0, 0, 0, 0, 0);
    issue("and",   4'b0000, 8'hCC,  8'hAA,  8'h88,  8'h00, 8'h00, 0, 0, 0, 0, 0, 0);
    issue("or",    4'b0001, 8'hCC,  8'hAA,  8'hEE,  8'h00, 8'h00, 0, 0, 0, 0, 0, 0);
    issue("bad",   4'b0011, 8'h12,  8'h34,  8'h00,  8'h00, 8'h00, 0, 0, 0, 0, 0, 0);
    issue("mul1",  4'b1000, 8'd200, 8'd3,   8'h58,  8'h02, 8'h58, 0, 0, 0, 0, 8, 0);
    issue("mul2",  4'b1000, 8'd255, 8'd255, 8'h01,  8'hFE, 8'h01, 0, 0, 0, 0, 8, 1);
    issue("add_hold", 4'b0010, 8'd1, 8'd1,  8'h02,  8'hFE, 8'h01, 0, 0, 0, 0, 0, 0);
    issue("div1",  4'b1001, 8'd200, 8'd7,   8'h1C,  8'h04, 8'h1C, 0, 0, 0, 0, 8, 0);
    issue("div2",  4'b1001, 8'd5,   8'd9,   8'h00,  8'h05, 8'h00, 1, 0, 0, 0, 8, 0);
    issue("div0",  4'b1001, 8'd77,  8'd0,   8'hFF,  8'h4D, 8'hFF, 0, 0, 0, 1, 0, 0);
    issue("add_dz", 4'b0010, 8'd1,  8'd1,   8'h02,  8'h4D, 8'hFF, 0, 0, 0, 1, 0, 0);
    issue("div3",  4'b1001, 8'd9,   8'd3,   8'h03,  8'h00, 8'h03, 0, 0, 0, 0, 8, 0);
    // abort a MULTU in its 4th busy cycle with an asynchronous reset
    @(negedge clk);
    bus.operacion_i = 4'b1000; bus.a_i = 8'd200; bus.b_i = 8'd3; bus.start_i = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort.busy_before", {31'd0, bus.busy_o}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("abort.outs", {bus.resultado_o, bus.hi_o, bus.lo_o, 8'd0}, 32'd0);
    chk("abort.flags", {26'd0, bus.zero_o, bus.overflow_o, bus.c_o, bus.div_cero_o, bus.busy_o, bus.done_o}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    issue("after_rst", 4'b0010, 8'd1, 8'd2, 8'h03, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    chk("queue_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/alu_multiciclo_nbits.md
Name: alu_multiciclo_nbits

Overview:
Parametrised N-bit sequential ALU for the multicycle datapath. It extends the ripple ALU's logic, add/sub, SLT and NOR operations with registered outputs and flags. It adds unsigned multiply (shift-add) and unsigned divide (restoring), both iterative with HI/LO result registers. It sits between the register file operand latches and the control FSM, and talks to the FSM through a start/busy/done handshake.

Parameters:
N, 8, operand width in bits (N >= 4).

Ports:
clk_i  input  1  clock; all state changes on the rising edge.
rst_i  input  1  reset; asynchronous, active-high.
start_i  input  1  launch operation; sampled only in IDLE.
a_i  input  N  operand A; latched at start.
b_i  input  N  operand B; latched at start.
operacion_i  input  4  operation code; latched at start.
resultado_o  output  N  registered result (LO for MULTU/DIVU).
hi_o  output  N  HI register: product high half, or division remainder.
lo_o  output  N  LO register: product low half, or quotient.
zero_o  output  1  resultado_o == 0.
overflow_o  output  1  signed overflow of ADD/SUB.
c_o  output  1  carry-out of ADD/SUB.
div_cero_o  output  1  last DIVU had divisor 0.
busy_o  output  1  multicycle operation in progress.
done_o  output  1  one-cycle pulse: outputs are valid and updated.

Behaviour:
- Reset (async, any state): FSM -> IDLE; every output and internal register is 0.
- Opcodes: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB (A + ~B + 1), 0111 SLT (signed; result is {N-1 zeros, A<B}), 1100 NOR, 1000 MULTU, 1001 DIVU. Any other code gives result 0 and all flags 0; it is handled as a single-cycle op.
- States: IDLE, MUL, DIV, DONE.
- Single-cycle ops:
  - start_i high in IDLE at edge k: resultado_o, zero_o, c_o and overflow_o update at edge k.
  - FSM -> DONE at edge k; done_o is high in the following cycle; FSM -> IDLE at edge k+1.
  - hi_o, lo_o and div_cero_o are held unchanged.
- MULTU:
  - At edge k: latch operands; clear the 2N-bit accumulator; counter = N; busy_o = 1; FSM -> MUL.
  - Each MUL cycle: if multiplier LSB = 1, add the multiplicand into the accumulator high half (N+1-bit sum). Then shift the accumulator right by 1, shift the multiplier right by 1, and decrement the counter.
  - At edge k+N: {hi_o, lo_o} = A*B; resultado_o = lo_o; busy_o = 0; FSM -> DONE.
  - done_o is high in cycle k+N..k+N+1.
  - c_o and overflow_o = 0; zero_o reflects resultado_o.
- DIVU:
  - Restoring division, N iterations.
  - Each iteration: shift {remainder, quotient} left by 1; trial = remainder - B. If trial >= 0, remainder = trial and quotient LSB = 1; otherwise quotient LSB = 0.
  - Timing is identical to MULTU: lo_o = quotient, hi_o = remainder, resultado_o = quotient, div_cero_o = 0.
- DIVU with b_i = 0:
  - No iteration; FSM -> DONE at edge k.
  - lo_o = all ones, hi_o = A, resultado_o = all ones, div_cero_o = 1.
  - div_cero_o holds until the next DIVU completes.
- Handshake:
  - start_i is ignored in MUL, DIV and DONE; no queuing.
  - Changes on a_i, b_i or operacion_i after the start edge have no effect.
  - done_o never coincides with busy_o = 1.
  - Back-to-back starts: the next start is accepted in the IDLE cycle after DONE, so the minimum issue interval is 2 cycles for single-cycle ops and N+2 cycles for MULTU/DIVU.
- Reset mid-operation: the operation is abandoned, all outputs return to 0, and no done_o pulse is produced.
- Widths: all arithmetic is unsigned modulo 2^N except SLT and overflow_o, which use two's complement.
  - overflow_o for ADD = (A[N-1] == B[N-1]) && (R[N-1] != A[N-1]).
  - overflow_o for SUB uses ~B in place of B.

Test Plan (N=8):
- ADD a=100, b=27 -> next cycle: resultado_o=127, c_o=0, overflow_o=0, done_o one-cycle pulse. ADD 100+100 -> 0xC8, overflow_o=1, c_o=0. ADD 0xFF+0x01 -> 0x00, c_o=1, zero_o=1.
- SUB 5-7 -> 0xFE, c_o=0. SLT 5,7 -> 0x01. SLT 0x80,0x01 -> 0x01 (signed). NOR 0xF0,0x0F -> 0x00, zero_o=1.
- MULTU 200*3 -> busy_o high for 8 cycles, then hi_o=0x02, lo_o=0x58, resultado_o=0x58, done_o pulses once. 255*255 -> hi_o=0xFE, lo_o=0x01. Pulse start_i mid-busy with different operands -> ignored, same result.
- DIVU 200/7 -> lo_o=28 (0x1C), hi_o=4, div_cero_o=0 after 8 busy cycles. 5/9 -> lo_o=0, hi_o=5, zero_o=1.
- DIVU 77/0 -> done_o in the cycle after start with no busy_o, lo_o=0xFF, hi_o=77 (0x4D), div_cero_o=1. A following DIVU 9/3 -> lo_o=3, div_cero_o=0.
- Assert rst_i asynchronously in the 4th MUL cycle -> all outputs 0 immediately. After release, no done_o; a new start_i is accepted in IDLE.
